// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: splits instruction fields, classifies the format and
// assembles the sign-extended immediate into a registered, valid/ready-handshaked entry.
// Define DECODE_SKID_EN for a two-entry skid buffer with a flopped in_ready.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  fmt_e               dec_fmt;
  logic signed [31:0] dec_imm32;
  entry_t             dec_entry;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        7'b0110011:                         dec_fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111:             dec_fmt = FMT_I;
        7'b0100011:                         dec_fmt = FMT_S;
        7'b1100011:                         dec_fmt = FMT_B;
        7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
        7'b1101111:                         dec_fmt = FMT_J;
        default:                            dec_fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    dec_imm32 = '0;
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: dec_imm32 = {in_instr[31:12], 12'b0};
      FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = in_pc;
    dec_entry.opcode  = in_instr[6:0];
    dec_entry.rd      = in_instr[11:7];
    dec_entry.rs1     = in_instr[19:15];
    dec_entry.rs2     = in_instr[24:20];
    dec_entry.funct3  = in_instr[14:12];
    dec_entry.funct7  = in_instr[31:25];
    dec_entry.fmt     = dec_fmt;
    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    dec_entry.imm     = XLEN'(dec_imm32);
    dec_entry.illegal = (dec_fmt == FMT_ILL);
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic   main_valid_q, main_valid_d;
  entry_t main_q, main_d;
  logic   in_fire, out_fire;

  assign out_fire = main_valid_q && out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  logic   skid_valid_q, skid_valid_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low while the skid slot is occupied, so only a drain can happen.
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_ready) begin
        main_valid_d = 1'b1;
        main_d       = dec_entry;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = dec_entry;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_d       = dec_entry;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // NOTE: the data payload is reset too, because every out_* must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
`ifdef DECODE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
`ifdef DECODE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_valid   = main_valid_q;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_fmt     = main_q.fmt;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, immediates, backpressure ordering,
// flush and asynchronous reset; works with or without DECODE_SKID_EN.
module tb_decode_stage;
  localparam int XLEN = 32;
`ifdef DECODE_SKID_EN
  localparam int   CAP     = 2;
  localparam logic RST_RDY = 1'b0;
`else
  localparam int   CAP     = 1;
  localparam logic RST_RDY = 1'b1;
`endif

  logic            clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3, out_fmt;
  logic            out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_instr [3];
  logic [31:0] bp_pc    [3];
  logic [31:0] bp_imm   [3];
  logic [31:0] got_pc   [$];
  logic [31:0] got_imm  [$];
  int          k;
  logic        fire, ofire;
  int          seen;

  initial begin
    bp_instr = '{32'h01230293, 32'hFE208EE3, 32'h12345537};
    bp_pc    = '{32'h200, 32'h204, 32'h208};
    bp_imm   = '{32'h00000012, 32'hFFFFFFFC, 32'h12345000};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_in_ready", in_ready, RST_RDY);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Single-instruction decode with the consumer always ready.
    out_ready = 1'b1;
    send_one(32'h01230293, 32'h100);
    check("addi_valid", out_valid, 1);
    check("addi_fmt", out_fmt, 1);
    check("addi_rd", out_rd, 5);
    check("addi_rs1", out_rs1, 6);
    check("addi_funct3", out_funct3, 0);
    check("addi_imm", out_imm, 32'h00000012);
    check("addi_illegal", out_illegal, 0);
    check("addi_pc", out_pc, 32'h100);

    send_one(32'hFE208EE3, 32'h104);
    check("beq_fmt", out_fmt, 3);
    check("beq_rs1", out_rs1, 1);
    check("beq_rs2", out_rs2, 2);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_pc", out_pc, 32'h104);

    send_one(32'h12345537, 32'h108);
    check("lui_fmt", out_fmt, 4);
    check("lui_rd", out_rd, 10);
    check("lui_imm", out_imm, 32'h12345000);

    send_one(32'h00000000, 32'h10C);
    check("zero_fmt", out_fmt, 7);
    check("zero_illegal", out_illegal, 1);
    check("zero_imm", out_imm, 0);

    send_one(32'hFE512C23, 32'h110);
    check("sw_fmt", out_fmt, 2);
    check("sw_rs2", out_rs2, 5);
    check("sw_imm", out_imm, 32'hFFFFFFF8);

    send_one(32'h001000EF, 32'h114);
    check("jal_fmt", out_fmt, 5);
    check("jal_rd", out_rd, 1);
    check("jal_imm", out_imm, 32'h00000800);

    send_one(32'h01230290, 32'h118);
    check("lowbits_fmt", out_fmt, 7);
    check("lowbits_illegal", out_illegal, 1);
    check("lowbits_imm", out_imm, 0);
    check("lowbits_raw_rd", out_rd, 5);
    check("lowbits_raw_rs1", out_rs1, 6);

    step();
    check("drained_valid", out_valid, 0);

    // Backpressure: consumer stalled for three cycles.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instr = bp_instr[k];
      in_pc    = bp_pc[k];
      #1;
      fire = in_ready;
      @(posedge clk);
      #1;
      if (fire) k++;
      check("bp_hold_pc", out_pc, 32'h200);
      check("bp_hold_imm", out_imm, 32'h12);
    end
    check("bp_accepts", k, CAP);
    check("bp_in_ready_low", in_ready, 0);

    out_ready = 1'b1;
    for (int c = 0; c < 20 && got_pc.size() < 3; c++) begin
      in_valid = (k < 3);
      if (k < 3) begin
        in_instr = bp_instr[k];
        in_pc    = bp_pc[k];
      end
      #1;
      fire  = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire) begin
        got_pc.push_back(out_pc[31:0]);
        got_imm.push_back(out_imm[31:0]);
      end
      @(posedge clk);
      #1;
      if (fire) k++;
    end
    in_valid = 1'b0;
    check("bp_drain_count", got_pc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_pc.size()) begin
        check("bp_order_pc", got_pc[i], bp_pc[i]);
        check("bp_order_imm", got_imm[i], bp_imm[i]);
      end
    end
    check("bp_empty_after", out_valid, 0);

    // Flush with the stage full and a new instruction offered.
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) send_one(32'h01230293, 32'h300 + 32'(4 * i));
    check("flush_full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h12345537;
    in_pc     = 32'h3FC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) seen++;
    end
    check("flush_no_ghost", seen, 0);

    // Asynchronous reset in the middle of a held entry.
    out_ready = 1'b0;
    send_one(32'hFE208EE3, 32'h400);
    check("pre_rst_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rd", out_rd, 0);
    check("mid_rst_imm", out_imm, 0);
    check("mid_rst_pc", out_pc, 0);
    check("mid_rst_fmt", out_fmt, 0);
    check("mid_rst_in_ready", in_ready, RST_RDY);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("rerun_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_one(32'h12345537, 32'h500);
    check("rerun_valid", out_valid, 1);
    check("rerun_fmt", out_fmt, 4);
    check("rerun_rd", out_rd, 10);
    check("rerun_imm", out_imm, 32'h12345000);
    check("rerun_pc", out_pc, 32'h500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
